c2c_monitor_sampler: RTL and testbench
======================================

Name: c2c_monitor_sampler

Overview:
Measurement front end that feeds the C2C monitor wrapper datapath.
- On a trigger, it starts the three replicated C2C monitors and collects their two-lane counts.
- It applies the configured vote (single monitor or median) and the configured scale.
- It presents one c2c_count_t result over a valid/ready handshake to the wrapper's result arithmetic.

Parameters:
COUNT_W, c2c_monitor_pkg::C2C_COUNT_W, width of one count lane
TIMEOUT_CYCLES, 1024, max cycles in WAIT before the measurement is aborted
N_MON, 3, number of replicated monitors (fixed 3; vote encoding depends on it)

Ports:
i_clk  in  1  block clock
i_rst_n  in  1  asynchronous active-low reset
i_trigger  in  1  start a measurement (single-cycle pulse or level; sampled only in IDLE)
i_cfg_vote  in  2  c2c_vote_opt_e: c2c_0/c2c_1/c2c_2 select one monitor, medium_vote = median of 3
i_cfg_scale  in  4  right-shift amount applied to each voted lane
o_mon_start  out  N_MON  one-cycle start pulse per monitor
i_mon_done  in  N_MON  per-monitor done pulse
i_mon_count  in  N_MON*2*COUNT_W  per-monitor c2c_count_t; valid in the cycle its done is high
o_count  out  2*COUNT_W  voted, scaled c2c_count_t
o_count_valid  out  1  result valid
i_count_ready  in  1  consumer accepts the result
o_busy  out  1  high in every state except IDLE
o_timeout  out  1  one-cycle pulse on abort

Behaviour:
Reset values:
- All outputs are 0.
- The FSM is in IDLE.
- Done flags and capture registers are 0.

FSM states: IDLE, START, WAIT, VOTE, OUT.

IDLE:
- When i_trigger=1, latch i_cfg_vote and i_cfg_scale into shadow regs.
- Clear the done flags and the timeout counter, then go to START.
- Config changes after this point do not affect the measurement in progress.

START:
- For one cycle, drive o_mon_start with the required set: one-hot for c2c_n, 3'b111 for medium_vote.
- Go to WAIT.

WAIT:
- For each required monitor, when its i_mon_done=1: set its sticky flag and capture its i_mon_count.
- A repeat done overwrites the capture (last value wins).
- Done from a non-required monitor is ignored.
- When all required flags are set, counting the current cycle's done, go to VOTE.
- The timeout counter increments each WAIT cycle.
- If the counter reaches TIMEOUT_CYCLES-1 without completion: pulse o_timeout, go to IDLE, produce no output.
- If completion and the timeout occur in the same cycle, completion wins.

VOTE:
- Per lane k (0,1), independently:
  - c2c_n: v = cap[n][k].
  - medium_vote: v = median(cap[0][k], cap[1][k], cap[2][k]), unsigned compare; ties give the duplicated value.
- o_count[k] is registered as v >> scale, a logical shift.
- A scale of COUNT_W or more yields 0.
- Go to OUT.

OUT:
- o_count_valid=1.
- o_count is stable until the handshake.
- When i_count_ready=1, go to IDLE; o_count_valid drops next cycle.
- o_count keeps its last value until the next VOTE.

Latency: the trigger sampled at cycle T gives o_mon_start at T+1. If the last required done arrives at cycle D, o_count_valid is high at D+2. When i_count_ready is held high, throughput is 1 measurement per (D-T)+3 cycles.

Boundary conditions:
- A trigger outside IDLE is ignored; no queueing.
- Done pulses outside WAIT are ignored, including a done in the same cycle as START.
- Reset asserted mid-operation forces IDLE and zero outputs asynchronously. Monitors see no further start pulse.
- The ready/valid handshake follows the AXI-stream rule: valid never depends on ready.

Decomposition:
Shared package c2c_monitor_wrapper_pkg:
- Already defines c2c_count_t, c2c_vote_opt_e and SCALE_WD; reuse them for ports and the shadow cfg.
- Add a sampler state enum c2c_sampler_state_e and C2C_N_MON=3 there.

Sub-module c2c_median3: purely combinational median of three COUNT_W unsigned values. Instantiate it twice, once per lane.

Test Plan:
1. vote=c2c_1, scale=0, trigger at T. Monitor 1 done at T+5 with counts {0x1234,0x0567}. Required: o_mon_start=3'b010 at T+1, valid at T+7, o_count={0x1234,0x0567}, other monitors not started.
2. vote=medium_vote, scale=2. Lane0 counts {100,300,200}; lane1 {50,50,90}; dones at different cycles. Required: o_count={50,12}, valid 2 cycles after the last done.
3. medium_vote, monitor 2 never done. Required: o_timeout pulse exactly TIMEOUT_CYCLES cycles after entering WAIT, o_count_valid stays 0, return to IDLE, o_busy drops.
4. Hold i_count_ready=0 for 10 cycles in OUT and pulse i_trigger and change cfg during that time. Required: o_count stable, valid held, trigger ignored. After ready, exactly one transfer, then IDLE.
5. Assert i_rst_n=0 in WAIT and in OUT. Required: all outputs 0 immediately, no further start pulses. After release, a new trigger starts a clean measurement.
6. c2c_0 with scale=15 and count 0xFFFF (COUNT_W=16) -> output 0x0001. Also drive a done on an unselected monitor and a second done on the selected monitor in WAIT -> the capture uses the selected monitor's latest value.

Source files
------------

// File: rtl/c2c_monitor_wrapper_pkg.sv
// Shared types for the C2C monitor wrapper and its measurement sampler.
// Holds the count format, the vote options and the sampler FSM state encoding.
// The count word packs lane0 in the upper half and lane1 in the lower half.
package c2c_monitor_wrapper_pkg;

  localparam int C2C_COUNT_W = 16;
  localparam int SCALE_WD    = 4;
  localparam int C2C_N_MON   = 3;

  typedef struct packed {
    logic [C2C_COUNT_W-1:0] lane0;
    logic [C2C_COUNT_W-1:0] lane1;
  } c2c_count_t;

  typedef enum logic [1:0] {
    c2c_0       = 2'd0,
    c2c_1       = 2'd1,
    c2c_2       = 2'd2,
    medium_vote = 2'd3
  } c2c_vote_opt_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_VOTE  = 3'd3,
    S_OUT   = 3'd4
  } c2c_sampler_state_e;

  // Monitors that must report before a vote can be taken.
  function automatic logic [C2C_N_MON-1:0] c2c_req_mask(input c2c_vote_opt_e vote);
    logic [C2C_N_MON-1:0] mask;
    case (vote)
      c2c_0:   mask = 3'b001;
      c2c_1:   mask = 3'b010;
      c2c_2:   mask = 3'b100;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/c2c_median3.sv
// Median of three unsigned values.
// Latency: purely combinational.
// Backpressure: none.
module c2c_median3 #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_med
);

  logic [W-1:0] lo_ab;
  logic [W-1:0] hi_ab;
  logic [W-1:0] hi_min_c;

  // median = max(min(a,b), min(max(a,b), c)); duplicated values fall out naturally
  always_comb begin
    lo_ab    = (i_a < i_b) ? i_a : i_b;
    hi_ab    = (i_a < i_b) ? i_b : i_a;
    hi_min_c = (hi_ab < i_c) ? hi_ab : i_c;
    o_med    = (lo_ab > hi_min_c) ? lo_ab : hi_min_c;
  end

endmodule

// File: rtl/c2c_monitor_sampler.sv
// Starts the replicated C2C monitors on a trigger, votes and scales their counts.
// Latency: start pulse 1 cycle after trigger; result valid 2 cycles after last required done.
// Backpressure: result held in OUT until ready; triggers outside IDLE are dropped, not queued.
module c2c_monitor_sampler
  import c2c_monitor_wrapper_pkg::*;
#(
  parameter int COUNT_W        = C2C_COUNT_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int N_MON          = C2C_N_MON
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_trigger,
  input  c2c_vote_opt_e              i_cfg_vote,
  input  logic [SCALE_WD-1:0]        i_cfg_scale,
  output logic [N_MON-1:0]           o_mon_start,
  input  logic [N_MON-1:0]           i_mon_done,
  input  logic [N_MON*2*COUNT_W-1:0] i_mon_count,
  output logic [2*COUNT_W-1:0]       o_count,
  output logic                       o_count_valid,
  input  logic                       i_count_ready,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  c2c_sampler_state_e   state_q, state_d;
  c2c_vote_opt_e        vote_q, vote_d;
  logic [SCALE_WD-1:0]  scale_q, scale_d;
  logic [N_MON-1:0]     flags_q, flags_d;
  logic [2*COUNT_W-1:0] cap_q [N_MON];
  logic [2*COUNT_W-1:0] cap_d [N_MON];
  logic [TO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [2*COUNT_W-1:0] count_q, count_d;

  logic [N_MON-1:0]     req;
  logic [N_MON-1:0]     hit;
  logic [COUNT_W-1:0]   med_l0, med_l1;
  logic [COUNT_W-1:0]   sel_l0, sel_l1;

  assign req = c2c_req_mask(vote_q);

  c2c_median3 #(.W(COUNT_W)) u_med_lane0 (
    .i_a   (cap_q[0][2*COUNT_W-1:COUNT_W]),
    .i_b   (cap_q[1][2*COUNT_W-1:COUNT_W]),
    .i_c   (cap_q[2][2*COUNT_W-1:COUNT_W]),
    .o_med (med_l0)
  );

  c2c_median3 #(.W(COUNT_W)) u_med_lane1 (
    .i_a   (cap_q[0][COUNT_W-1:0]),
    .i_b   (cap_q[1][COUNT_W-1:0]),
    .i_c   (cap_q[2][COUNT_W-1:0]),
    .o_med (med_l1)
  );

  // Pick the voted value per lane from the shadow vote setting
  always_comb begin
    sel_l0 = med_l0;
    sel_l1 = med_l1;
    case (vote_q)
      c2c_0: begin
        sel_l0 = cap_q[0][2*COUNT_W-1:COUNT_W];
        sel_l1 = cap_q[0][COUNT_W-1:0];
      end
      c2c_1: begin
        sel_l0 = cap_q[1][2*COUNT_W-1:COUNT_W];
        sel_l1 = cap_q[1][COUNT_W-1:0];
      end
      c2c_2: begin
        sel_l0 = cap_q[2][2*COUNT_W-1:COUNT_W];
        sel_l1 = cap_q[2][COUNT_W-1:0];
      end
      default: ;
    endcase
  end

  // Next-state logic: FSM transitions, done capture, timeout and result
  always_comb begin
    state_d   = state_q;
    vote_d    = vote_q;
    scale_d   = scale_q;
    flags_d   = flags_q;
    cap_d     = cap_q;
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = 1'b0;
    count_d   = count_q;
    hit       = i_mon_done & req;

    case (state_q)
      S_IDLE: begin
        if (i_trigger) begin
          vote_d    = i_cfg_vote;
          scale_d   = i_cfg_scale;
          flags_d   = '0;
          tmo_cnt_d = '0;
          state_d   = S_START;
        end
      end

      S_START: state_d = S_WAIT;

      S_WAIT: begin
        for (int n = 0; n < N_MON; n++) begin
          if (hit[n]) cap_d[n] = i_mon_count[n*2*COUNT_W +: 2*COUNT_W];
        end
        flags_d = flags_q | hit;
        // completion is checked first so it wins over a same-cycle timeout
        if ((flags_d & req) == req) begin
          state_d = S_VOTE;
        end else if (tmo_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_VOTE: begin
        if (int'(scale_q) >= COUNT_W) begin
          count_d = '0;
        end else begin
          count_d = {sel_l0 >> scale_q, sel_l1 >> scale_q};
        end
        state_d = S_OUT;
      end

      S_OUT: begin
        if (i_count_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      vote_q    <= c2c_0;
      scale_q   <= '0;
      flags_q   <= '0;
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      for (int n = 0; n < N_MON; n++) cap_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      vote_q    <= vote_d;
      scale_q   <= scale_d;
      flags_q   <= flags_d;
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      for (int n = 0; n < N_MON; n++) cap_q[n] <= cap_d[n];
    end
  end

  assign o_mon_start   = (state_q == S_START) ? req : '0;
  assign o_count_valid = (state_q == S_OUT);
  assign o_busy        = (state_q != S_IDLE);
  assign o_timeout     = timeout_q;
  assign o_count       = count_q;

endmodule

// File: tb/tb_c2c_monitor_sampler.sv
// Directed bench for c2c_monitor_sampler: one linear stimulus sequence with
// hand-computed expectations checked by immediate assertions at negedge.
module tb_c2c_monitor_sampler;
  import c2c_monitor_wrapper_pkg::*;

  localparam int W = 16;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_trigger;
  c2c_vote_opt_e i_cfg_vote;
  logic [3:0]    i_cfg_scale;
  logic [2:0]    o_mon_start;
  logic [2:0]    i_mon_done;
  logic [95:0]   i_mon_count;
  logic [31:0]   o_count;
  logic          o_count_valid;
  logic          i_count_ready;
  logic          o_busy;
  logic          o_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic seen_v, seen_t;

  c2c_monitor_sampler #(.COUNT_W(W), .TIMEOUT_CYCLES(1024), .N_MON(3)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_trigger     (i_trigger),
    .i_cfg_vote    (i_cfg_vote),
    .i_cfg_scale   (i_cfg_scale),
    .o_mon_start   (o_mon_start),
    .i_mon_done    (i_mon_done),
    .i_mon_count   (i_mon_count),
    .o_count       (o_count),
    .o_count_valid (o_count_valid),
    .i_count_ready (i_count_ready),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] pack(input int n, input logic [15:0] l0, input logic [15:0] l1);
    logic [95:0] r;
    r = '0;
    r[n*32 +: 32] = {l0, l1};
    return r;
  endfunction

  initial begin
    i_rst_n = 1'b0; i_trigger = 1'b0; i_cfg_vote = c2c_0; i_cfg_scale = 4'd0;
    i_mon_done = 3'b000; i_mon_count = '0; i_count_ready = 1'b0;
    tick(2);
    chk("rst_valid", o_count_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_mon_start, 0);
    chk("rst_timeout", o_timeout, 0);
    i_rst_n = 1'b1;
    tick(1);

    // single monitor c2c_1, scale 0, done at T+5
    i_cfg_vote = c2c_1; i_cfg_scale = 4'd0; i_trigger = 1'b1;
    tick(1);                                    // T+1
    i_trigger = 1'b0;
    chk("t1_start", o_mon_start, 3'b010);
    chk("t1_busy", o_busy, 1);
    tick(1);                                    // T+2
    chk("t1_start_off", o_mon_start, 0);
    tick(3);                                    // T+5
    i_mon_done = 3'b010; i_mon_count = pack(1, 16'h1234, 16'h0567);
    tick(1);                                    // T+6
    i_mon_done = 3'b000; i_mon_count = '0;
    chk("t1_valid_early", o_count_valid, 0);
    tick(1);                                    // T+7
    chk("t1_valid", o_count_valid, 1);
    chk("t1_count", o_count, 32'h1234_0567);
    i_count_ready = 1'b1;
    tick(1);
    i_count_ready = 1'b0;
    chk("t1_valid_drop", o_count_valid, 0);
    chk("t1_idle", o_busy, 0);

    // median vote, scale 2, staggered dones; then hold in OUT with ready low
    i_cfg_vote = medium_vote; i_cfg_scale = 4'd2; i_trigger = 1'b1;
    tick(1);                                    // T+1
    i_trigger = 1'b0;
    chk("t2_start", o_mon_start, 3'b111);
    tick(2);                                    // T+3
    i_mon_done = 3'b001; i_mon_count = pack(0, 16'd100, 16'd50);
    tick(1);                                    // T+4
    i_mon_done = 3'b100; i_mon_count = pack(2, 16'd200, 16'd90);
    tick(1);                                    // T+5
    i_mon_done = 3'b000; i_mon_count = '0;
    tick(1);                                    // T+6
    i_mon_done = 3'b010; i_mon_count = pack(1, 16'd300, 16'd50);
    tick(1);                                    // T+7
    i_mon_done = 3'b000; i_mon_count = '0;
    chk("t2_valid_early", o_count_valid, 0);
    tick(1);                                    // T+8
    chk("t2_valid", o_count_valid, 1);
    chk("t2_count", o_count, {16'd50, 16'd12});
    for (int i = 0; i < 10; i++) begin
      if (i == 2) i_trigger = 1'b1;
      if (i == 3) i_trigger = 1'b0;
      if (i == 4) begin i_cfg_vote = c2c_0; i_cfg_scale = 4'd0; end
      tick(1);
      chk("t4_hold_count", o_count, {16'd50, 16'd12});
      chk("t4_hold_valid", o_count_valid, 1);
    end
    i_count_ready = 1'b1;
    tick(1);
    i_count_ready = 1'b0;
    chk("t4_valid_drop", o_count_valid, 0);
    chk("t4_idle", o_busy, 0);
    tick(1);
    chk("t4_no_queued_start", o_mon_start, 0);
    chk("t4_still_idle", o_busy, 0);

    // c2c_0, scale 15; done during START and on an unselected monitor are ignored
    i_cfg_vote = c2c_0; i_cfg_scale = 4'd15; i_trigger = 1'b1;
    tick(1);                                    // T+1 (START)
    i_trigger = 1'b0;
    i_mon_done = 3'b001; i_mon_count = pack(0, 16'h0000, 16'h0000);
    tick(1);                                    // T+2
    i_mon_done = 3'b000; i_mon_count = '0;
    tick(1);                                    // T+3
    i_mon_done = 3'b010; i_mon_count = pack(1, 16'hFFFF, 16'hFFFF);
    tick(1);                                    // T+4
    chk("t6_valid_early", o_count_valid, 0);
    i_mon_done = 3'b001; i_mon_count = pack(0, 16'hFFFF, 16'h8000);
    tick(1);                                    // T+5
    i_mon_done = 3'b000; i_mon_count = '0;
    chk("t6_valid_before", o_count_valid, 0);
    tick(1);                                    // T+6
    chk("t6_valid", o_count_valid, 1);
    chk("t6_count", o_count, {16'h0001, 16'h0001});
    i_count_ready = 1'b1;
    tick(1);
    i_count_ready = 1'b0;

    // median vote with a repeated done on monitor 0: last value wins
    i_cfg_vote = medium_vote; i_cfg_scale = 4'd0; i_trigger = 1'b1;
    tick(1);                                    // T+1
    i_trigger = 1'b0;
    tick(1);                                    // T+2
    i_mon_done = 3'b001; i_mon_count = pack(0, 16'd10, 16'd10);
    tick(1);                                    // T+3
    i_mon_done = 3'b001; i_mon_count = pack(0, 16'd40, 16'd40);
    tick(1);                                    // T+4
    i_mon_done = 3'b110;
    i_mon_count = pack(1, 16'd30, 16'd20) | pack(2, 16'd20, 16'd30);
    tick(1);                                    // T+5
    i_mon_done = 3'b000; i_mon_count = '0;
    tick(1);                                    // T+6
    chk("t6b_valid", o_count_valid, 1);
    chk("t6b_count", o_count, {16'd30, 16'd30});
    i_count_ready = 1'b1;
    tick(1);
    i_count_ready = 1'b0;

    // reset while in WAIT
    i_cfg_vote = medium_vote; i_trigger = 1'b1;
    tick(1);
    i_trigger = 1'b0;
    tick(2);                                    // WAIT
    chk("t5w_busy_pre", o_busy, 1);
    i_rst_n = 1'b0;
    #1;
    chk("t5w_busy", o_busy, 0);
    chk("t5w_count", o_count, 0);
    chk("t5w_start", o_mon_start, 0);
    tick(1);
    chk("t5w_start_hold", o_mon_start, 0);
    tick(1);
    i_rst_n = 1'b1;
    tick(1);
    chk("t5w_start_after", o_mon_start, 0);

    // reset while in OUT
    i_cfg_vote = c2c_2; i_cfg_scale = 4'd0; i_trigger = 1'b1;
    tick(1);
    i_trigger = 1'b0;
    tick(2);                                    // T+3
    i_mon_done = 3'b100; i_mon_count = pack(2, 16'hBEEF, 16'hCAFE);
    tick(1);
    i_mon_done = 3'b000; i_mon_count = '0;
    tick(1);                                    // T+5
    chk("t5o_valid_pre", o_count_valid, 1);
    chk("t5o_count_pre", o_count, 32'hBEEF_CAFE);
    i_rst_n = 1'b0;
    #1;
    chk("t5o_valid", o_count_valid, 0);
    chk("t5o_count", o_count, 0);
    chk("t5o_busy", o_busy, 0);
    tick(2);
    i_rst_n = 1'b1;
    tick(1);

    // clean measurement after reset: c2c_2, scale 1
    i_cfg_vote = c2c_2; i_cfg_scale = 4'd1; i_trigger = 1'b1;
    tick(1);
    i_trigger = 1'b0;
    chk("t5c_start", o_mon_start, 3'b100);
    tick(2);                                    // T+3
    i_mon_done = 3'b100; i_mon_count = pack(2, 16'h0010, 16'h0020);
    tick(1);
    i_mon_done = 3'b000; i_mon_count = '0;
    tick(1);                                    // T+5
    chk("t5c_valid", o_count_valid, 1);
    chk("t5c_count", o_count, {16'h0008, 16'h0010});
    i_count_ready = 1'b1;
    tick(1);
    i_count_ready = 1'b0;

    // timeout: median vote, monitor 2 never reports; WAIT entered at T+2
    i_cfg_vote = medium_vote; i_cfg_scale = 4'd0; i_trigger = 1'b1;
    tick(1);                                    // T+1
    i_trigger = 1'b0;
    chk("t3_start", o_mon_start, 3'b111);
    seen_v = 1'b0; seen_t = 1'b0;
    for (int c = 2; c <= 1025; c++) begin
      tick(1);                                  // T+c
      seen_v |= o_count_valid;
      seen_t |= o_timeout;
      if (c == 3) begin
        i_mon_done  = 3'b011;
        i_mon_count = pack(0, 16'd1, 16'd1) | pack(1, 16'd2, 16'd2);
      end else begin
        i_mon_done  = 3'b000;
        i_mon_count = '0;
      end
    end
    chk("t3_no_valid", seen_v, 0);
    chk("t3_no_early_timeout", seen_t, 0);
    chk("t3_busy_last_wait", o_busy, 1);
    tick(1);                                    // T+1026
    chk("t3_timeout", o_timeout, 1);
    chk("t3_idle", o_busy, 0);
    chk("t3_valid", o_count_valid, 0);
    tick(1);
    chk("t3_timeout_pulse", o_timeout, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
